// File: rtl/move_sequencer.sv
// Move sequencer for a 3x3 board. It arbitrates player and AI moves by turn, validates
// each move, strobes the board, confirms the turn flipped, and detects win, tie or new game.
module move_sequencer #(
  parameter int unsigned SUBMIT_HI  = 2,
  parameter int unsigned SETTLE_MAX = 8,
  parameter int unsigned CELLS      = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 player_req,
  input  logic [3:0]           player_loc,
  output logic                 player_ack,
  input  logic                 ai_req,
  input  logic [3:0]           ai_loc,
  output logic                 ai_ack,
  output logic                 move_err,
  input  logic                 board_turn,
  input  logic [2*CELLS-1:0]   board_state,
  output logic [3:0]           update_loc,
  output logic                 submit,
  output logic                 board_clr,
  input  logic                 new_game,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 fault
);

  localparam int unsigned CNT_MAX = (SUBMIT_HI > SETTLE_MAX) ? SUBMIT_HI : SETTLE_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    CLEAR_HI, CLEAR_LO, WAIT, PULSE, SETTLE, CHECK, OVER, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             turn_q, turn_d;
  logic [3:0]       update_loc_q, update_loc_d;
  logic             submit_q, submit_d;
  logic             board_clr_q, board_clr_d;
  logic             player_ack_q, player_ack_d;
  logic             ai_ack_q, ai_ack_d;
  logic             move_err_q, move_err_d;
  logic             game_over_q, game_over_d;
  logic [1:0]       winner_q, winner_d;
  logic             fault_q, fault_d;

  logic [1:0]  cell_c [CELLS];
  logic [15:0] occ_c;
  logic [1:0]  lw_c [8];
  logic [1:0]  win_c;
  logic        full_c;
  logic        req_c;
  logic [3:0]  idx_c;
  logic        bad_c;

  function automatic logic [1:0] line_win(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
    if ((a == b) && (b == c) && ((a == 2'b01) || (a == 2'b10))) return a;
    return 2'b00;
  endfunction

  // Cell decode: code 11 counts as blank, so only 01/10 occupy a cell.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < CELLS; i++) begin
      cell_c[i] = board_state[2*i +: 2];
      occ_c[i]  = (cell_c[i] == 2'b01) || (cell_c[i] == 2'b10);
    end
  end

  always_comb begin
    lw_c[0] = line_win(cell_c[0], cell_c[1], cell_c[2]);
    lw_c[1] = line_win(cell_c[3], cell_c[4], cell_c[5]);
    lw_c[2] = line_win(cell_c[6], cell_c[7], cell_c[8]);
    lw_c[3] = line_win(cell_c[0], cell_c[3], cell_c[6]);
    lw_c[4] = line_win(cell_c[1], cell_c[4], cell_c[7]);
    lw_c[5] = line_win(cell_c[2], cell_c[5], cell_c[8]);
    lw_c[6] = line_win(cell_c[0], cell_c[4], cell_c[8]);
    lw_c[7] = line_win(cell_c[2], cell_c[4], cell_c[6]);
    win_c   = 2'b00;
    for (int k = 0; k < 8; k++) begin
      if (win_c == 2'b00) win_c = lw_c[k];
    end
    full_c = &occ_c[CELLS-1:0];
  end

  // Only the requester that owns the current turn is ever looked at.
  always_comb begin
    req_c = board_turn ? ai_req : player_req;
    idx_c = board_turn ? ai_loc : player_loc;
    bad_c = (idx_c >= 4'(CELLS)) || occ_c[idx_c];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    turn_d       = turn_q;
    update_loc_d = update_loc_q;
    submit_d     = 1'b0;
    board_clr_d  = 1'b0;
    player_ack_d = 1'b0;
    ai_ack_d     = 1'b0;
    move_err_d   = 1'b0;
    game_over_d  = 1'b0;
    winner_d     = winner_q;
    fault_d      = fault_q;
    case (state_q)
      CLEAR_HI: begin
        board_clr_d = 1'b1;
        if (cnt_q == CNT_W'(SUBMIT_HI)) begin
          cnt_d   = '0;
          state_d = CLEAR_LO;
        end else begin
          submit_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      CLEAR_LO: begin
        winner_d = 2'b00;
        state_d  = WAIT;
      end
      WAIT: begin
        if (req_c) begin
          player_ack_d = ~board_turn;
          ai_ack_d     = board_turn;
          if (bad_c) begin
            move_err_d = 1'b1;
          end else begin
            update_loc_d = idx_c;
            turn_d       = board_turn;
            cnt_d        = '0;
            state_d      = PULSE;
          end
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(SUBMIT_HI)) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          submit_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (board_turn != turn_q) begin
          state_d = CHECK;
        end else if (cnt_q == CNT_W'(SETTLE_MAX - 1)) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (win_c != 2'b00) begin
          winner_d    = win_c;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else if (full_c) begin
          winner_d    = 2'b00;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          state_d = WAIT;
        end
      end
      OVER: begin
        if (new_game) begin
          cnt_d   = '0;
          state_d = CLEAR_HI;
        end else begin
          game_over_d = 1'b1;
        end
      end
      HALT: ;
      default: state_d = CLEAR_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR_HI;
      cnt_q        <= '0;
      turn_q       <= 1'b0;
      update_loc_q <= 4'd0;
      submit_q     <= 1'b0;
      board_clr_q  <= 1'b0;
      player_ack_q <= 1'b0;
      ai_ack_q     <= 1'b0;
      move_err_q   <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      turn_q       <= turn_d;
      update_loc_q <= update_loc_d;
      submit_q     <= submit_d;
      board_clr_q  <= board_clr_d;
      player_ack_q <= player_ack_d;
      ai_ack_q     <= ai_ack_d;
      move_err_q   <= move_err_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      fault_q      <= fault_d;
    end
  end

  assign update_loc = update_loc_q;
  assign submit     = submit_q;
  assign board_clr  = board_clr_q;
  assign player_ack = player_ack_q;
  assign ai_ack     = ai_ack_q;
  assign move_err   = move_err_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a behavioural board answers submit strobes, and
// expected acks are queued at issue time and checked by an independent monitor.
module tb_move_sequencer;

  localparam int SUBMIT_HI  = 2;
  localparam int SETTLE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        player_req, ai_req, new_game;
  logic [3:0]  player_loc, ai_loc;
  logic        player_ack, ai_ack, move_err;
  logic        board_turn;
  logic [17:0] board_state;
  logic [3:0]  update_loc;
  logic        submit, board_clr, game_over, fault;
  logic [1:0]  winner;

  move_sequencer #(.SUBMIT_HI(SUBMIT_HI), .SETTLE_MAX(SETTLE_MAX), .CELLS(9)) dut (
    .clk(clk), .reset(reset),
    .player_req(player_req), .player_loc(player_loc), .player_ack(player_ack),
    .ai_req(ai_req), .ai_loc(ai_loc), .ai_ack(ai_ack), .move_err(move_err),
    .board_turn(board_turn), .board_state(board_state),
    .update_loc(update_loc), .submit(submit), .board_clr(board_clr),
    .new_game(new_game), .game_over(game_over), .winner(winner), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { bit who; bit err; logic [3:0] loc; } exp_t;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  bit armed    = 1'b0;
  bit stuck    = 1'b0;

  // Behavioural board: acts on the falling edge of submit.
  logic [1:0] brd [9] = '{default: 2'b00};
  logic       turn_b  = 1'b0;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always @(negedge submit) begin
    if (armed) begin
      if (board_clr) begin
        for (int i = 0; i < 9; i++) brd[i] = 2'b00;
        turn_b = 1'b0;
      end else if (!stuck && update_loc < 4'd9) begin
        brd[update_loc] = turn_b ? 2'b10 : 2'b01;
        turn_b = ~turn_b;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) board_state[2*i +: 2] = brd[i];
  end
  assign board_turn = turn_b;

  function automatic logic [1:0] ref_winner();
    for (int l = 0; l < 8; l++) begin
      if (brd[lines[l][0]] != 2'b00 && brd[lines[l][0]] != 2'b11 &&
          brd[lines[l][0]] == brd[lines[l][1]] && brd[lines[l][1]] == brd[lines[l][2]])
        return brd[lines[l][0]];
    end
    return 2'b00;
  endfunction

  function automatic bit ref_full();
    for (int i = 0; i < 9; i++) if (brd[i] != 2'b01 && brd[i] != 2'b10) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on every ack and measures each submit pulse.
  task automatic monitor();
    int         hi = 0;
    logic [3:0] loc0 = 4'd0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (armed && !reset) begin
        if (player_ack || ai_ack) begin
          chk("single_ack", int'(player_ack) + int'(ai_ack), 1);
          chk("ack_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_source", int'(ai_ack), int'(e.who));
            chk("move_err", int'(move_err), int'(e.err));
            if (!e.err) chk("accept_loc", int'(update_loc), int'(e.loc));
          end
        end
        if (submit) begin
          if (hi == 0) loc0 = update_loc;
          else chk("loc_stable", int'(update_loc), int'(loc0));
          hi++;
        end else if (hi != 0) begin
          chk("submit_width", hi, SUBMIT_HI);
          chk("loc_hold", int'(update_loc), int'(loc0));
          pulses++;
          hi = 0;
        end
      end else begin
        hi = 0;
      end
    end
  endtask

  task automatic check_clear();
    int n = 0;
    while (!board_clr && n < 10) begin @(negedge clk); n++; end
    chk("clr_rise", int'(board_clr), 1);
    chk("clr_submit", int'(submit), 1);
    for (int i = 1; i < SUBMIT_HI; i++) begin
      @(negedge clk);
      chk("clr_submit_hold", int'(submit), 1);
      chk("clr_hold", int'(board_clr), 1);
    end
    @(negedge clk);
    chk("clr_submit_low", int'(submit), 0);
    chk("clr_after_submit", int'(board_clr), 1);
    @(negedge clk);
    chk("clr_fall", int'(board_clr), 0);
    chk("clr_game_over", int'(game_over), 0);
    chk("clr_winner", int'(winner), 0);
  endtask

  task automatic drive_req(input bit who, input logic [3:0] loc);
    if (who) begin ai_req = 1'b1; ai_loc = loc; end
    else begin player_req = 1'b1; player_loc = loc; end
  endtask

  task automatic drop_req();
    player_req = 1'b0;
    ai_req     = 1'b0;
  endtask

  // One request from `who`; entered and left on a falling clock edge.
  task automatic play(input bit who, input logic [3:0] loc, input bit other);
    exp_t e = '{who: 1'b0, err: 1'b0, loc: 4'd0};
    bit   elig = (who == turn_b);
    int   n;
    logic [1:0] w;
    bit   over;
    drive_req(who, loc);
    if (elig) begin
      if (other) drive_req(~who, 4'($urandom_range(0, 15)));
      e.who = who;
      e.err = (loc >= 4'd9) ? 1'b1 : (brd[loc] != 2'b00);
      e.loc = loc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    drop_req();
    if (elig && !e.err) begin
      n = 0;
      while (!submit && n < 5) begin @(negedge clk); n++; end
      chk("submit_rise", int'(submit), 1);
      n = 0;
      while (submit && n < 10) begin @(negedge clk); n++; end
      chk("submit_fall", int'(submit), 0);
      repeat (3) @(negedge clk);
      w    = ref_winner();
      over = (w != 2'b00) || ref_full();
      chk("game_over", int'(game_over), int'(over));
      chk("winner", int'(winner), over ? int'(w) : 0);
    end
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("over_fall", int'(game_over), 0);
    check_clear();
  endtask

  task automatic hold_reqs(input bit p, input bit a, input int cycles);
    int p0 = pulses;
    player_req = p; player_loc = 4'd6;
    ai_req     = a; ai_loc     = 4'd7;
    repeat (cycles) @(negedge clk);
    drop_req();
    @(negedge clk);
    chk("no_submit", pulses - p0, 0);
    chk("no_ack_pending", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         p0;
    int         guard;
    int         r;
    int         blanks [$];
    logic [3:0] loc;
    logic [3:0] tie_loc [9];

    reset = 1'b1;
    player_req = 1'b0; ai_req = 1'b0; new_game = 1'b0;
    player_loc = 4'd0; ai_loc = 4'd0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_update_loc", int'(update_loc), 0);
    chk("rst_submit", int'(submit), 0);
    chk("rst_board_clr", int'(board_clr), 0);
    chk("rst_acks", int'(player_ack) + int'(ai_ack), 0);
    chk("rst_move_err", int'(move_err), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_fault", int'(fault), 0);
    armed = 1'b1;
    reset = 1'b0;
    check_clear();

    // Player X at centre, then AI rejected on occupied and out-of-range cells.
    play(1'b0, 4'd4, 1'b0);
    chk("turn_after_x", int'(turn_b), 1);
    p0 = pulses;
    play(1'b1, 4'd4, 1'b0);
    play(1'b1, 4'd9, 1'b0);
    @(negedge clk);
    chk("reject_no_submit", pulses - p0, 0);
    play(1'b1, 4'd0, 1'b0);

    // Non-owner requests and new_game outside OVER are ignored.
    new_game = 1'b1;
    hold_reqs(1'b0, 1'b1, 20);
    new_game = 1'b0;
    chk("no_clear_outside_over", int'(board_clr), 0);

    // Reset in the middle of a submit pulse.
    drive_req(1'b0, 4'd8);
    exp_q.push_back('{who: 1'b0, err: 1'b0, loc: 4'd8});
    @(negedge clk);
    drop_req();
    n = 0;
    while (!submit && n < 5) begin @(negedge clk); n++; end
    chk("mid_submit_rise", int'(submit), 1);
    reset = 1'b1;
    #1;
    chk("mid_submit_async_drop", int'(submit), 0);
    @(negedge clk);
    reset = 1'b0;
    check_clear();

    // X wins on the top row.
    play(1'b0, 4'd0, 1'b0);
    play(1'b1, 4'd3, 1'b0);
    play(1'b0, 4'd1, 1'b0);
    play(1'b1, 4'd4, 1'b0);
    play(1'b0, 4'd2, 1'b0);
    chk("x_win_over", int'(game_over), 1);
    chk("x_win_winner", int'(winner), 1);
    hold_reqs(1'b1, 1'b1, 5);
    chk("over_holds", int'(game_over), 1);
    start_new_game();

    // Full board without a line.
    tie_loc = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    for (int i = 0; i < 9; i++) play(turn_b, tie_loc[i], 1'b0);
    chk("tie_over", int'(game_over), 1);
    chk("tie_winner", int'(winner), 0);
    start_new_game();

    // Randomised games against the reference board.
    for (int g = 0; g < 4; g++) begin
      guard = 0;
      while (!game_over && guard < 80) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          drive_req(~turn_b, 4'($urandom_range(0, 15)));
          repeat (2) @(negedge clk);
          drop_req();
          @(negedge clk);
        end else begin
          blanks.delete();
          for (int i = 0; i < 9; i++) if (brd[i] == 2'b00) blanks.push_back(i);
          if (r <= 2 || blanks.size() == 0) loc = 4'($urandom_range(0, 15));
          else loc = 4'(blanks[$urandom_range(0, blanks.size() - 1)]);
          play(turn_b, loc, r == 3);
        end
        guard++;
      end
      chk("rand_game_over", int'(game_over), 1);
      start_new_game();
    end

    // Board never flips its turn: fault after SETTLE_MAX cycles, then HALT.
    stuck = 1'b1;
    drive_req(1'b0, 4'd0);
    exp_q.push_back('{who: 1'b0, err: 1'b0, loc: 4'd0});
    @(negedge clk);
    drop_req();
    n = 0;
    while (!submit && n < 5) begin @(negedge clk); n++; end
    chk("fault_submit_rise", int'(submit), 1);
    n = 0;
    while (submit && n < 10) begin @(negedge clk); n++; end
    chk("fault_submit_fall", int'(submit), 0);
    n = 0;
    while (!fault && n < 40) begin @(negedge clk); n++; end
    chk("fault_latency", n, SETTLE_MAX);
    chk("fault_set", int'(fault), 1);
    hold_reqs(1'b1, 1'b1, 10);
    chk("fault_sticky", int'(fault), 1);
    stuck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("fault_cleared", int'(fault), 0);
    reset = 1'b0;
    check_clear();

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Clocked controller that owns the board block's move interface: `update_loc`, `submit`, `reset`.
- Arbitrates between the human-player move source and the AI move source. Only the requester whose turn it is gets served.
- Validates each move, generates a clean `submit` pulse, and confirms the board accepted it by watching the turn flag flip.
- Detects win or stalemate from the board state, then runs a new-game clear sequence on request.

Parameters:
- SUBMIT_HI, default 2: cycles `submit` is held high per move (minimum 1).
- SETTLE_MAX, default 8: cycles to wait for `board_turn` to toggle after `submit` falls before flagging a fault.
- CELLS, default 9: number of board cells. Fixed 3x3; other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- player_req  in  1  player has a move pending.
- player_loc  in  4  player cell index, 0..8.
- player_ack  out  1  one-cycle pulse: player move consumed; `move_err` is valid in the same cycle.
- ai_req  in  1  AI has a move pending.
- ai_loc  in  4  AI cell index.
- ai_ack  out  1  one-cycle pulse: AI move consumed.
- move_err  out  1  qualifies an ack; 1 = move rejected (out-of-range index or occupied cell).
- board_turn  in  1  turn flag from the board; 0 = player (X), 1 = AI (O).
- board_state  in  18  cell i at bits [2i+1:2i]; 00 blank, 01 X, 10 O, 11 invalid (treated as blank).
- update_loc  out  4  cell index to the board.
- submit  out  1  board strobe; the board acts on its falling edge.
- board_clr  out  1  drives the board's reset input.
- new_game  in  1  level request to clear and restart, honoured only in OVER.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none/tie, 01 X, 10 O; valid while `game_over` is high.
- fault  out  1  sticky: board did not toggle its turn within SETTLE_MAX. Cleared only by `reset`.

Behaviour:
- Reset values (async):
  - Outputs: `update_loc`=0, `submit`=0, `board_clr`=0, all acks=0, `move_err`=0, `game_over`=0, `winner`=0, `fault`=0.
  - FSM = CLEAR, so the board is always wiped after reset.
- States: CLEAR_HI, CLEAR_LO, WAIT, PULSE, SETTLE, CHECK, OVER, HALT.
- CLEAR_HI:
  - `board_clr`=1, `submit`=1 for SUBMIT_HI cycles, then go to CLEAR_LO.
- CLEAR_LO:
  - `submit`=0 while `board_clr` stays 1 for one cycle, so the board samples reset at the falling edge.
  - Then drop `board_clr`, clear `winner`, go to WAIT.
- WAIT:
  - Eligible requester is `player_req` when `board_turn`=0, `ai_req` when `board_turn`=1. The other requester is ignored and never acked.
  - On an eligible request, compute idx from the corresponding loc.
  - Reject if idx ≥ 9 or cell idx is 01/10: pulse that requester's ack with `move_err`=1 and stay in WAIT.
  - Accept otherwise: latch idx into `update_loc`, pulse ack with `move_err`=0, go to PULSE.
  - Ack is issued in the cycle after `req` is sampled. The requester must drop `req` or change loc after its ack; a `req` still high the cycle after an ack is treated as a new request.
- PULSE:
  - `submit`=1 for SUBMIT_HI cycles. `update_loc` is stable for the whole pulse and one cycle beyond.
  - Then `submit`=0, go to SETTLE.
- SETTLE:
  - Wait for `board_turn` to differ from the value latched at accept, then go to CHECK.
  - If SETTLE_MAX cycles pass without a toggle: set `fault`, go to HALT.
- CHECK (1 cycle):
  - Evaluate the 8 lines from `board_state`: rows 012/345/678, columns 036/147/258, diagonals 048/246.
  - Win: all three cells equal and equal to 01 or 10. Set `winner` to that value, go to OVER.
  - Else all 9 cells non-blank: `winner`=00, go to OVER.
  - Else go to WAIT.
- OVER:
  - `game_over`=1; no requests are acked.
  - `new_game`=1 goes to CLEAR_HI; `game_over` falls on that transition.
- HALT:
  - Absorbing state; only `reset` exits.
- `reset` asserted mid-pulse: `submit` drops asynchronously. Any board falling edge this creates is superseded by the CLEAR sequence.
- `new_game` outside OVER is ignored.
- Simultaneous `player_req` and `ai_req`: only the turn owner is considered. No priority rule is needed.

Test Plan:
- Reset release → CLEAR sequence: `board_clr`=1, `submit` high 2 cycles then low, `board_clr` low one cycle later; state WAIT; `game_over`=0.
- `board_turn`=0, `player_req` with loc=4 → `player_ack` pulse with `move_err`=0; `update_loc`=4; `submit` high exactly 2 cycles. Bench model flips the turn; back in WAIT within SETTLE+CHECK.
- Cell 4=01, `board_turn`=1, `ai_req` loc=4, then loc=9 → two `ai_ack` pulses, each with `move_err`=1; `submit` stays 0.
- `board_turn`=0 with only `ai_req` asserted for 20 cycles → no ack, `submit` stays 0.
- Board model reaches X on 0,1,2 → after CHECK, `game_over`=1, `winner`=01; further requests unacked. `new_game` pulse → CLEAR, `winner`=00.
- Board model never toggles the turn → `fault`=1 exactly SETTLE_MAX cycles after `submit` falls; FSM stays in HALT until `reset`.
- Full board with no line → `game_over`=1, `winner`=00.
